taillight_cmd_ctrl: RTL and testbench
=====================================

// Module: taillight_cmd_ctrl
// PURPOSE
//   Driver-side command front end for the taillight sequencer. Takes raw, bouncy
//   board inputs (turn buttons, hazard button, brake pedal, run switch) and
//   produces clean registered levels left/right/brake/hazard/runlight.
//   Those outputs drive the taillight inputs of the same names directly.
//   Includes synchronisation, debouncing, latched turn signals with auto-cancel,
//   and a toggled hazard.
// PARAMETERS
//   DEB_CYCLES    16   consecutive stable samples required to accept an input change (>=1)
//   TURN_TIMEOUT  256  cycles a latched turn signal stays on before auto-cancel; 0 = never
// PORTS
//   clk         in   1  system clock
//   rst         in   1  synchronous reset, active-high
//   btn_left    in   1  raw left-turn pushbutton (async, bouncy)
//   btn_right   in   1  raw right-turn pushbutton (async, bouncy)
//   btn_hazard  in   1  raw hazard pushbutton (async, bouncy)
//   brake_pedal in   1  raw brake level (async, bouncy)
//   sw_run      in   1  raw running-light switch level (async, bouncy)
//   left        out  1  left turn command (registered)
//   right       out  1  right turn command (registered)
//   brake       out  1  brake command (registered)
//   hazard      out  1  hazard command (registered)
//   runlight    out  1  running-light command (registered)
// BEHAVIOUR
//   Reset: all outputs 0, sync/stable regs 0, debounce+turn counters 0, FSM IDLE.
//   Sync: each raw input passes through 2 flops before any use.
//   Debounce, per input, counter width $clog2(DEB_CYCLES+1):
//   - synced==stable -> counter cleared.
//   - synced!=stable -> counter increments.
//   - On the DEB_CYCLES-th consecutive differing sample: stable<=synced, counter cleared.
//   - Any single matching sample restarts the count.
//   - Latency from a clean raw edge to a stable change: 2+DEB_CYCLES cycles.
//   Edge detect: 1-cycle pulse on a stable 0->1 of left, right and hazard buttons only.
//   - Releases generate no pulse.
//   brake = stable brake_pedal, runlight = stable sw_run; each registered, +1 cycle.
//   Hazard: T flop, toggles on each hazard pulse; independent of turn FSM.
//   - left/right are not masked while hazard=1.
//   Turn FSM states IDLE / LEFT / RIGHT; left=(state==LEFT), right=(state==RIGHT).
//   - Mutually exclusive by construction.
//   - IDLE : lpulse&!rpulse -> LEFT; rpulse&!lpulse -> RIGHT; both/neither -> IDLE.
//   - LEFT : lpulse&!rpulse -> IDLE (manual cancel); rpulse&!lpulse -> RIGHT.
//            Both pulses in the same cycle -> IDLE.
//   - RIGHT: symmetric to LEFT.
//   Turn timer:
//   - Cleared on every entry into LEFT or RIGHT, including LEFT->RIGHT.
//   - Increments each cycle while in LEFT or RIGHT.
//   - When it reaches TURN_TIMEOUT-1 and no pulse arrives, next state is IDLE.
//     Left/right is high for exactly TURN_TIMEOUT cycles.
//   - A pulse in the timeout cycle takes priority over the timeout.
//   - TURN_TIMEOUT=0 disables the timer.
//   Output timing: state, hazard and output regs update the cycle after the pulse.
//   - Press-to-output latency: 2 sync + DEB_CYCLES + 1 edge + 1 reg cycles.
//   Reset mid-operation: returns to the reset state on the next edge.
//   - An input held across reset re-debounces from stable=0.
//   - For a held button this yields one pulse (a toggle) after DEB_CYCLES+2 cycles.
// TESTING (DEB_CYCLES=4, TURN_TIMEOUT=20)
//   1. rst=1 for 5 cycles, all inputs 1 -> all outputs 0 while rst=1.
//      After release, held btn_left gives left=1 at cycle 8.
//   2. btn_left glitches 1/0 every 2 cycles for 20 cycles, then held 1 -> no change
//      during glitching; left=1 exactly 8 cycles after the clean hold starts.
//   3. Left latched, no further input -> left=1 for exactly 20 cycles, then 0.
//      right stays 0 throughout.
//   4. Left latched, right pressed at cycle 5 -> left falls and right rises on the same edge.
//      right then holds 20 cycles. A second right press -> right=0.
//   5. Two hazard presses 30 cycles apart, left latched in between -> hazard=1 then 0.
//      left stays independent; left=1 and hazard=1 coexist.
//   6. brake_pedal=1 held, sw_run pulsed 1 for 3 cycles -> brake=1 after 7 cycles.
//      runlight never asserts (pulse shorter than DEB_CYCLES).

Source files
------------

// File: rtl/taillight_cmd_ctrl_if.sv
// Bundle of the raw board inputs and clean command outputs of the taillight
// command front end.
//   btn_left, btn_right, btn_hazard : raw pushbuttons (async, bouncy)
//   brake_pedal, sw_run             : raw levels (async, bouncy)
//   left, right, brake, hazard,
//   runlight                        : registered command levels
// The master side is the board/stimulus; the slave side is the controller.
interface taillight_cmd_ctrl_if;
  logic btn_left;
  logic btn_right;
  logic btn_hazard;
  logic brake_pedal;
  logic sw_run;
  logic left;
  logic right;
  logic brake;
  logic hazard;
  logic runlight;

  modport master (
    output btn_left, btn_right, btn_hazard, brake_pedal, sw_run,
    input  left, right, brake, hazard, runlight
  );

  modport slave (
    input  btn_left, btn_right, btn_hazard, brake_pedal, sw_run,
    output left, right, brake, hazard, runlight
  );
endinterface

// File: rtl/taillight_cmd_ctrl.sv
// Driver-side command front end for the taillight sequencer.
// Raw inputs are double-flop synchronised and debounced. Turn buttons latch a
// turn signal that cancels on a second press or after TURN_TIMEOUT cycles.
// The hazard button toggles the hazard output. Brake and run switch are
// passed through as clean levels.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : taillight_cmd_ctrl_if.slave (raw inputs in, command levels out)
// Parameters:
//   DEB_CYCLES   : consecutive differing samples needed to accept a change (>=1)
//   TURN_TIMEOUT : cycles a latched turn stays on; 0 disables auto-cancel
module taillight_cmd_ctrl #(
  parameter int DEB_CYCLES   = 16,
  parameter int TURN_TIMEOUT = 256
) (
  input logic                 clk,
  input logic                 rst,
  taillight_cmd_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);

  // Bit positions of each input in the packed input vectors
  localparam int IL = 4;
  localparam int IR = 3;
  localparam int IH = 2;
  localparam int IB = 1;
  localparam int IS = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  logic [4:0]    raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    stable;
  logic [4:0]    stable_d;
  logic [CW-1:0] deb_cnt [5];
  logic          lpulse;
  logic          rpulse;
  logic          hpulse;
  logic          brake_q;
  logic          run_q;
  logic          hazard_q;
  state_t        state;
  state_t        next_state;
  logic [TW-1:0] turn_timer;
  logic          timeout;
  logic          left_o;
  logic          right_o;

  assign raw = {bus.btn_left, bus.btn_right, bus.btn_hazard, bus.brake_pedal, bus.sw_run};

  // Two-flop synchroniser; nothing downstream looks at sync1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-input debounce: count consecutive samples that disagree with the
  // accepted level; a single agreeing sample throws the count away.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered rising-edge pulses for the pushbuttons, registered brake/run
  // levels, and the hazard toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d <= '0;
      lpulse   <= 1'b0;
      rpulse   <= 1'b0;
      hpulse   <= 1'b0;
      brake_q  <= 1'b0;
      run_q    <= 1'b0;
      hazard_q <= 1'b0;
    end else begin
      stable_d <= stable;
      lpulse   <= stable[IL] & ~stable_d[IL];
      rpulse   <= stable[IR] & ~stable_d[IR];
      hpulse   <= stable[IH] & ~stable_d[IH];
      brake_q  <= stable[IB];
      run_q    <= stable[IS];
      if (hpulse) hazard_q <= ~hazard_q;
    end
  end

  // Turn FSM state register; the timer restarts on every entry into a turn
  // state (including a direct LEFT<->RIGHT switch) so each turn gets the full
  // TURN_TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      turn_timer <= '0;
    end else begin
      state <= next_state;
      if (next_state == IDLE || next_state != state) begin
        turn_timer <= '0;
      end else if (TURN_TIMEOUT != 0) begin
        turn_timer <= turn_timer + 1'b1;
      end
    end
  end

  // Next-state logic; a pulse in the timeout cycle wins over the timeout, and
  // simultaneous left+right pulses always land in IDLE.
  always_comb begin
    next_state = state;
    timeout    = (TURN_TIMEOUT != 0) && (turn_timer == TURN_LAST);
    case (state)
      IDLE: begin
        if (lpulse && !rpulse)      next_state = LEFT;
        else if (rpulse && !lpulse) next_state = RIGHT;
      end
      LEFT: begin
        if (lpulse)       next_state = IDLE;
        else if (rpulse)  next_state = RIGHT;
        else if (timeout) next_state = IDLE;
      end
      RIGHT: begin
        if (rpulse)       next_state = IDLE;
        else if (lpulse)  next_state = LEFT;
        else if (timeout) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Turn outputs are a decode of the state register
  always_comb begin
    left_o  = (state == LEFT);
    right_o = (state == RIGHT);
  end

  assign bus.left     = left_o;
  assign bus.right    = right_o;
  assign bus.brake    = brake_q;
  assign bus.hazard   = hazard_q;
  assign bus.runlight = run_q;

endmodule

// File: tb/tb_taillight_cmd_ctrl.sv
// Self-checking bench for taillight_cmd_ctrl with DEB_CYCLES=4, TURN_TIMEOUT=20.
// Inputs are packed as {btn_left, btn_right, btn_hazard, brake_pedal, sw_run};
// outputs as {left, right, brake, hazard, runlight}. Each step drives inputs,
// pushes the expected outputs, advances a fixed number of clocks and then pops
// and compares against the DUT.
module tb_taillight_cmd_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] raw;
    logic [7:0] cycles;
    logic [4:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  logic [4:0] exp_q[$];
  string      name_q[$];
  vec_t       vecs[$];

  taillight_cmd_ctrl_if bus ();

  taillight_cmd_ctrl #(
    .DEB_CYCLES  (4),
    .TURN_TIMEOUT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the DUT outputs
  task automatic checkOutput();
    logic [4:0] act;
    logic [4:0] exp;
    string      nm;
    act = {bus.left, bus.right, bus.brake, bus.hazard, bus.runlight};
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard: empty queue, got %b", act);
    end else begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      if (act !== exp) begin
        mismatched++;
        $display("[TB] FAIL %s: got {L,R,B,H,RUN}=%b required %b", nm, act, exp);
      end
    end
  endtask

  // Drive inputs, record the expectation, run n clocks, sample 1ns after the edge
  task automatic applyStimulus(input logic r, input logic [4:0] raw, input int n,
                               input logic [4:0] exp, input string nm);
    rst            = r;
    bus.btn_left   = raw[4];
    bus.btn_right  = raw[3];
    bus.btn_hazard = raw[2];
    bus.brake_pedal = raw[1];
    bus.sw_run     = raw[0];
    exp_q.push_back(exp);
    name_q.push_back(nm);
    repeat (n) @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic addVec(input logic r, input logic [4:0] raw, input int n, input logic [4:0] exp);
    vec_t v;
    v.rst    = r;
    v.raw    = raw;
    v.cycles = 8'(n);
    v.exp    = exp;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset with all inputs high, then a held left button (right released)
    addVec(1, 5'b11111, 1, 5'b00000);
    addVec(1, 5'b11111, 4, 5'b00000);
    addVec(0, 5'b10111, 6, 5'b00000);
    addVec(0, 5'b10111, 1, 5'b00101);
    addVec(0, 5'b10111, 1, 5'b10111);
    // Left turn auto-cancels after exactly 20 cycles
    addVec(0, 5'b10111, 19, 5'b10111);
    addVec(0, 5'b10111, 1, 5'b00111);
    // Releases: brake/run drop, hazard stays set
    addVec(0, 5'b00000, 6, 5'b00111);
    addVec(0, 5'b00000, 1, 5'b00010);
    // Reset mid-operation clears on the next edge
    addVec(1, 5'b00000, 1, 5'b00000);
    addVec(1, 5'b00000, 1, 5'b00000);
    // Bouncing left button never gets through
    for (int k = 0; k < 5; k++) begin
      addVec(0, 5'b10000, 2, 5'b00000);
      addVec(0, 5'b00000, 2, 5'b00000);
    end
    // Clean hold: left exactly 8 cycles later
    addVec(0, 5'b10000, 7, 5'b00000);
    addVec(0, 5'b10000, 1, 5'b10000);
    // Right press overrides left on the same edge
    addVec(0, 5'b10000, 4, 5'b10000);
    addVec(0, 5'b11000, 7, 5'b10000);
    addVec(0, 5'b11000, 1, 5'b01000);
    // Second right press cancels right
    addVec(0, 5'b10000, 6, 5'b01000);
    addVec(0, 5'b11000, 7, 5'b01000);
    addVec(0, 5'b11000, 1, 5'b00000);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].raw, int'(vecs[i].cycles), vecs[i].exp,
                    $sformatf("vec%0d", i));
    end

    // Right pulse landing exactly in the left timeout cycle wins
    applyStimulus(0, 5'b00000, 6, 5'b00000, "prio_release");
    applyStimulus(0, 5'b10000, 7, 5'b00000, "prio_left_wait");
    applyStimulus(0, 5'b10000, 1, 5'b10000, "prio_left_on");
    applyStimulus(0, 5'b10000, 12, 5'b10000, "prio_left_hold");
    applyStimulus(0, 5'b11000, 7, 5'b10000, "prio_last_left_cycle");
    applyStimulus(0, 5'b11000, 1, 5'b01000, "prio_right_wins");
    applyStimulus(0, 5'b11000, 19, 5'b01000, "right_hold_19");
    applyStimulus(0, 5'b11000, 1, 5'b00000, "right_timeout");

    // Hazard toggles 30 cycles apart, coexisting with a left turn
    applyStimulus(0, 5'b00000, 6, 5'b00000, "haz_release");
    applyStimulus(0, 5'b00100, 7, 5'b00000, "haz1_wait");
    applyStimulus(0, 5'b00100, 1, 5'b00010, "haz1_on");
    applyStimulus(0, 5'b00000, 14, 5'b00010, "haz1_hold");
    applyStimulus(0, 5'b10000, 7, 5'b00010, "haz_left_wait");
    applyStimulus(0, 5'b10000, 1, 5'b10010, "haz_left_coexist");
    applyStimulus(0, 5'b10100, 7, 5'b10010, "haz2_wait");
    applyStimulus(0, 5'b10100, 1, 5'b10000, "haz2_off");
    applyStimulus(0, 5'b10100, 11, 5'b10000, "haz_left_hold");
    applyStimulus(0, 5'b10100, 1, 5'b00000, "haz_left_timeout");

    // Brake held, short run pulse rejected
    applyStimulus(0, 5'b00000, 6, 5'b00000, "brk_release");
    applyStimulus(0, 5'b00011, 3, 5'b00000, "brk_run_pulse");
    applyStimulus(0, 5'b00010, 3, 5'b00000, "brk_wait");
    applyStimulus(0, 5'b00010, 1, 5'b00100, "brk_on");
    applyStimulus(0, 5'b00010, 10, 5'b00100, "run_never");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
